lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit consuming the effective address produced by the ALU (rs1 + imm for I_type_ld / S_type) plus rs2 store data.
- Converts one load or store into a single word-aligned memory transaction with byte enables, waits for the response, and returns sign/zero-extended load data for register writeback.
- Sits between execute stage and data memory port; stalls the core through req_ready_out.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in WAIT_RSP without mem_rsp_valid_in before timeout error (>=1)

Ports:
- clk_in  input  1  clock, all state on rising edge
- rst_in  input  1  asynchronous active-high reset
- req_valid_in  input  1  core presents a memory instruction
- req_ready_out  output  1  LSU idle, request accepted when valid&&ready
- opcode_in  input  7  0000011 load, 0100011 store; anything else ignored
- funct3_in  input  3  access width/sign
- addr_in  input  32  effective address (ALU result)
- store_data_in  input  32  rs2 value
- mem_req_valid_out  output  1  memory request valid
- mem_req_ready_in  input  1  memory accepts request
- mem_addr_out  output  32  {addr[31:2],2'b00}
- mem_we_out  output  1  1 = store
- mem_be_out  output  4  byte enables
- mem_wdata_out  output  32  lane-aligned store data
- mem_rsp_valid_in  input  1  read data / write ack valid (one cycle)
- mem_rdata_in  input  32  read word
- done_out  output  1  one-cycle pulse, instruction finished (success or error)
- wb_valid_out  output  1  one-cycle pulse with done_out for successful loads only
- wb_data_out  output  32  extended load data, held until next done_out
- err_out  output  1  with done_out: instruction faulted
- err_cause_out  output  2  0 none, 1 misaligned, 2 illegal funct3, 3 timeout

Behaviour:
- Reset (async): state IDLE; req_ready_out=1; every other output 0; timeout counter 0. Reset mid-transaction aborts it, mem_req_valid_out drops immediately.
- FSM IDLE -> REQ -> WAIT_RSP -> DONE -> IDLE. req_ready_out=1 only in IDLE.
- IDLE: accept on req_valid_in && opcode load/store; latch opcode, funct3, addr, store_data. Other opcodes: no action, stay IDLE.
- Check on acceptance: illegal funct3 (load 011/110/111; store >=011) -> cause 2; misaligned (half addr[0]!=0, word addr[1:0]!=0) -> cause 1; fault goes to DONE, no memory transaction. Illegal funct3 takes priority.
- REQ: mem_req_valid_out=1, address/we/be/wdata stable until mem_req_ready_in; then WAIT_RSP, counter cleared. No timeout in REQ.
- Store lanes: SB be=0001<<addr[1:0], wdata={4{byte}}; SH be=0011<<{addr[1],1'b0}, wdata={2{half}}; SW be=1111.
- Loads: mem_we_out=0, be as for same width (informational).
- WAIT_RSP: on mem_rsp_valid_in capture data, go DONE. Counter increments otherwise; reaching TIMEOUT_CYCLES -> cause 3, DONE. Response in same cycle as limit wins (success).
- Load extract: shift rdata right by 8*addr[1:0]; LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW as is. Stores: wb_data_out unchanged.
- DONE (one cycle): done_out=1, err_out/err_cause_out valid, wb_valid_out=1 only for error-free load; next IDLE.
- Latency, zero-wait memory (ready and rsp next cycle): accept c0, REQ c1, rsp c2, done_out c3. Fault: accept c0, done_out c1.
- mem_rsp_valid_in outside WAIT_RSP ignored.
- Throughput: one instruction in flight; next accept earliest cycle after DONE.

Decomposition:
- lsu_pkg: opcode constants (LOAD, STORE), funct3 encodings (LB..LHU, SB..SW), state enum, err_cause enum.
- Sub-module lsu_align (combinational): store be/wdata generation and load extract/extend; instantiated once, unit-testable standalone.

Test Plan:
- SW addr=0x100 data=0xDEADBEEF, zero-wait memory -> mem_addr 0x100, be=1111, we=1, wdata 0xDEADBEEF, done_out 3 cycles after accept, err 0, no wb_valid.
- SB addr=0x203 data=0x000000A5 -> mem_addr 0x200, be=1000, wdata 0xA5A5A5A5.
- LB addr=0x102, rdata=0x12805634 -> wb_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x00001280.
- LW addr=0x106 -> no mem request, done_out next cycle, err=1 cause=1; load funct3=011 -> cause 2.
- LW with mem_req_ready_in low 5 cycles, no response, TIMEOUT_CYCLES=16 -> request held stable 5 cycles, done_out with cause 3 exactly 16 cycles after entering WAIT_RSP.
- rst_in pulsed while in WAIT_RSP -> mem_req_valid_out/done_out 0, req_ready_out 1 immediately; later response ignored; next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: opcodes, funct3 widths, FSM states, fault causes.
// Latency: n/a (declarations and one combinational helper).
// Backpressure: n/a.
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_MISALIGNED = 2'd1,
        CAUSE_ILLEGAL    = 2'd2,
        CAUSE_TIMEOUT    = 2'd3
    } err_cause_t;

    // Fault check at acceptance; an illegal width outranks a misaligned address.
    function automatic err_cause_t check_access(input logic is_store,
                                                input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic       illegal;
        logic       misaligned;
        err_cause_t cause;
        if (is_store) begin
            illegal = (funct3 > F3_SW);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        cause = CAUSE_NONE;
        if (illegal) begin
            cause = CAUSE_ILLEGAL;
        end else if (misaligned) begin
            cause = CAUSE_MISALIGNED;
        end
        return cause;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load extract with extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Lane selection from access width (funct3[1:0]) and low address bits.
    always_comb begin
        be      = 4'b1111;
        wdata   = store_data;
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'h0, shifted[7:0]};
            F3_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one core memory op -> one word-aligned memory transaction -> extended writeback.
// Latency: zero-wait memory gives done_out 3 cycles after accept; faults give done_out 1 cycle after.
// Backpressure: req_ready_out only in IDLE; mem request held stable until mem_req_ready_in.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [6:0]  opcode_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        mem_req_valid_out,
    input  logic        mem_req_ready_in,
    output logic [31:0] mem_addr_out,
    output logic        mem_we_out,
    output logic [3:0]  mem_be_out,
    output logic [31:0] mem_wdata_out,
    input  logic        mem_rsp_valid_in,
    input  logic [31:0] mem_rdata_in,
    output logic        done_out,
    output logic        wb_valid_out,
    output logic [31:0] wb_data_out,
    output logic        err_out,
    output logic [1:0]  err_cause_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [2:0]      funct3_q;
    logic [31:0]     addr_q;
    logic [31:0]     store_data_q;
    logic            is_store_q;
    err_cause_t      cause_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]     wb_data_q;

    logic            accept;
    err_cause_t      acc_cause;
    logic            timeout_hit;
    logic [3:0]      align_be;
    logic [31:0]     align_wdata;
    logic [31:0]     align_load;

    assign accept      = (state_q == ST_IDLE) && req_valid_in &&
                         ((opcode_in == OP_LOAD) || (opcode_in == OP_STORE));
    assign acc_cause   = check_access(opcode_in == OP_STORE, funct3_in, addr_in[1:0]);
    assign timeout_hit = (cnt_q == CNT_LAST);
    assign wb_data_out = wb_data_q;

    lsu_align u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (store_data_q),
        .rdata      (mem_rdata_in),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all outputs decode from the current state, so reset drops them at once.
    always_comb begin
        state_d           = state_q;
        req_ready_out     = 1'b0;
        mem_req_valid_out = 1'b0;
        mem_addr_out      = 32'h0;
        mem_we_out        = 1'b0;
        mem_be_out        = 4'h0;
        mem_wdata_out     = 32'h0;
        done_out          = 1'b0;
        wb_valid_out      = 1'b0;
        err_out           = 1'b0;
        err_cause_out     = 2'd0;
        case (state_q)
            ST_IDLE: begin
                req_ready_out = 1'b1;
                if (accept) begin
                    state_d = (acc_cause != CAUSE_NONE) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid_out = 1'b1;
                mem_addr_out      = {addr_q[31:2], 2'b00};
                mem_we_out        = is_store_q;
                mem_be_out        = align_be;
                mem_wdata_out     = is_store_q ? align_wdata : 32'h0;
                if (mem_req_ready_in) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rsp_valid_in || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_out      = 1'b1;
                err_out       = (cause_q != CAUSE_NONE);
                err_cause_out = cause_q;
                wb_valid_out  = !is_store_q && (cause_q == CAUSE_NONE);
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, response-wait counter and writeback register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            funct3_q     <= 3'h0;
            addr_q       <= 32'h0;
            store_data_q <= 32'h0;
            is_store_q   <= 1'b0;
            cause_q      <= CAUSE_NONE;
            cnt_q        <= '0;
            wb_data_q    <= 32'h0;
        end else begin
            if (accept) begin
                funct3_q     <= funct3_in;
                addr_q       <= addr_in;
                store_data_q <= store_data_in;
                is_store_q   <= (opcode_in == OP_STORE);
                cause_q      <= acc_cause;
            end
            if (state_q == ST_REQ) begin
                cnt_q <= '0;
            end
            if (state_q == ST_WAIT_RSP) begin
                // A response arriving on the last allowed cycle still counts as success.
                if (mem_rsp_valid_in) begin
                    if (!is_store_q) begin
                        wb_data_q <= align_load;
                    end
                end else if (timeout_hit) begin
                    cause_q <= CAUSE_TIMEOUT;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: scoreboard of expected completions, directed and random ops.
// Latency: checks exact completion cycle counts.
// Backpressure: exercises stalled mem_req_ready_in and missing responses.
module tb_lsu;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic [6:0]  opcode_in = 7'h0;
    logic [2:0]  funct3_in = 3'h0;
    logic [31:0] addr_in = 32'h0;
    logic [31:0] store_data_in = 32'h0;
    logic        mem_req_valid_out;
    logic        mem_req_ready_in = 1'b0;
    logic [31:0] mem_addr_out;
    logic        mem_we_out;
    logic [3:0]  mem_be_out;
    logic [31:0] mem_wdata_out;
    logic        mem_rsp_valid_in = 1'b0;
    logic [31:0] mem_rdata_in = 32'h0;
    logic        done_out;
    logic        wb_valid_out;
    logic [31:0] wb_data_out;
    logic        err_out;
    logic [1:0]  err_cause_out;

    lsu #(.TIMEOUT_CYCLES(16)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .req_valid_in      (req_valid_in),
        .req_ready_out     (req_ready_out),
        .opcode_in         (opcode_in),
        .funct3_in         (funct3_in),
        .addr_in           (addr_in),
        .store_data_in     (store_data_in),
        .mem_req_valid_out (mem_req_valid_out),
        .mem_req_ready_in  (mem_req_ready_in),
        .mem_addr_out      (mem_addr_out),
        .mem_we_out        (mem_we_out),
        .mem_be_out        (mem_be_out),
        .mem_wdata_out     (mem_wdata_out),
        .mem_rsp_valid_in  (mem_rsp_valid_in),
        .mem_rdata_in      (mem_rdata_in),
        .done_out          (done_out),
        .wb_valid_out      (wb_valid_out),
        .wb_data_out       (wb_data_out),
        .err_out           (err_out),
        .err_cause_out     (err_cause_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        err;
        logic [1:0]  cause;
        logic        wbv;
        logic [31:0] wbd;
        int          lat;
        int          nreq;
        logic [31:0] maddr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          mem_auto = 1'b0;
    bit          rsp_pend = 1'b0;
    logic [31:0] mem_word = 32'h0;
    int          req_cnt = 0;
    logic [31:0] cap_addr = 32'h0;
    logic        cap_we = 1'b0;
    logic [3:0]  cap_be = 4'h0;
    logic [31:0] cap_wdata = 32'h0;
    logic [31:0] last_wb = 32'h0;

    // Reference behaviour for one op.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] d,
                                   input logic [31:0] rd);
        exp_t        e;
        logic        st;
        logic        illegal;
        logic        mis;
        logic [31:0] s;
        st      = (op == ST);
        e.err   = 1'b0;
        e.cause = 2'd0;
        e.wbv   = 1'b0;
        e.wbd   = last_wb;
        e.lat   = 3;
        e.nreq  = 1;
        e.maddr = {a[31:2], 2'b00};
        e.we    = st;
        case (f3[1:0])
            2'b00:   begin e.be = 4'b0001 << a[1:0];         e.wd = {4{d[7:0]}};  end
            2'b01:   begin e.be = 4'b0011 << {a[1], 1'b0};   e.wd = {2{d[15:0]}}; end
            default: begin e.be = 4'b1111;                   e.wd = d;            end
        endcase
        illegal = st ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis     = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
        if (illegal || mis) begin
            e.err   = 1'b1;
            e.cause = illegal ? 2'd2 : 2'd1;
            e.lat   = 1;
            e.nreq  = 0;
        end else if (!st) begin
            s = rd >> (8 * a[1:0]);
            case (f3)
                3'd0:    e.wbd = {{24{s[7]}}, s[7:0]};
                3'd1:    e.wbd = {{16{s[15]}}, s[15:0]};
                3'd4:    e.wbd = {24'h0, s[7:0]};
                3'd5:    e.wbd = {16'h0, s[15:0]};
                default: e.wbd = rd;
            endcase
            e.wbv = 1'b1;
        end
        return e;
    endfunction

    // Advance to the next falling edge; run the zero-wait memory and log request handshakes.
    task automatic tick();
        @(negedge clk_in);
        cyc++;
        if (mem_auto) begin
            mem_rsp_valid_in = rsp_pend;
            mem_rdata_in     = rsp_pend ? mem_word : 32'h0;
            mem_req_ready_in = 1'b1;
            rsp_pend         = mem_req_valid_out;
        end
        if (mem_req_valid_out && mem_req_ready_in) begin
            req_cnt++;
            cap_addr  = mem_addr_out;
            cap_we    = mem_we_out;
            cap_be    = mem_be_out;
            cap_wdata = mem_wdata_out;
        end
    endtask

    // Issue one op against the auto memory and score its completion.
    task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
        exp_t e;
        int   acc;
        int   n0;
        bit   seen;
        exp_q.push_back(model(op, f3, a, d, rd));
        tick();
        total++;
        if (req_ready_out !== 1'b1) begin
            bad++; $display("FAIL %s ready_at_accept got=%b want=1", tag, req_ready_out);
        end
        req_valid_in = 1'b1; opcode_in = op; funct3_in = f3; addr_in = a;
        store_data_in = d; mem_word = rd;
        acc = cyc; n0 = req_cnt;
        tick();
        req_valid_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done_out === 1'b1) seen = 1'b1;
            else tick();
        end
        e = exp_q.pop_front();
        total++;
        if (!seen) begin
            bad++; $display("FAIL %s done_never_seen", tag);
        end else begin
            total += 6;
            if (cyc - acc !== e.lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", tag, cyc - acc, e.lat); end
            if (err_out !== e.err) begin bad++; $display("FAIL %s err got=%b want=%b", tag, err_out, e.err); end
            if (err_cause_out !== e.cause) begin bad++; $display("FAIL %s cause got=%0d want=%0d", tag, err_cause_out, e.cause); end
            if (wb_valid_out !== e.wbv) begin bad++; $display("FAIL %s wb_valid got=%b want=%b", tag, wb_valid_out, e.wbv); end
            if (wb_data_out !== e.wbd) begin bad++; $display("FAIL %s wb_data got=%h want=%h", tag, wb_data_out, e.wbd); end
            if (req_cnt - n0 !== e.nreq) begin bad++; $display("FAIL %s mem_reqs got=%0d want=%0d", tag, req_cnt - n0, e.nreq); end
            if (e.nreq == 1) begin
                total += 3;
                if (cap_addr !== e.maddr) begin bad++; $display("FAIL %s mem_addr got=%h want=%h", tag, cap_addr, e.maddr); end
                if (cap_we !== e.we) begin bad++; $display("FAIL %s mem_we got=%b want=%b", tag, cap_we, e.we); end
                if (cap_be !== e.be) begin bad++; $display("FAIL %s mem_be got=%b want=%b", tag, cap_be, e.be); end
                if (e.we) begin
                    total++;
                    if (cap_wdata !== e.wd) begin bad++; $display("FAIL %s mem_wdata got=%h want=%h", tag, cap_wdata, e.wd); end
                end
            end
        end
        if (e.wbv) last_wb = e.wbd;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick(); tick();
        total += 5;
        if (req_ready_out !== 1'b1) begin bad++; $display("FAIL reset ready got=%b want=1", req_ready_out); end
        if (mem_req_valid_out !== 1'b0) begin bad++; $display("FAIL reset mem_valid got=%b want=0", mem_req_valid_out); end
        if ({done_out, wb_valid_out, err_out, err_cause_out} !== 5'b0) begin
            bad++; $display("FAIL reset status got=%b want=0", {done_out, wb_valid_out, err_out, err_cause_out});
        end
        if (wb_data_out !== 32'h0) begin bad++; $display("FAIL reset wb_data got=%h want=0", wb_data_out); end
        if ({mem_addr_out, mem_we_out, mem_be_out, mem_wdata_out} !== 69'h0) begin
            bad++; $display("FAIL reset mem_bus got=%h want=0", {mem_addr_out, mem_we_out, mem_be_out, mem_wdata_out});
        end
        rst_in = 1'b0;
        mem_auto = 1'b1;
        tick();
        total++;
        if (req_ready_out !== 1'b1) begin bad++; $display("FAIL post_reset ready got=%b want=1", req_ready_out); end
    endtask

    task automatic test_store();
        run_op("sw", ST, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0);
        total += 3;
        if (cap_addr !== 32'h100) begin bad++; $display("FAIL sw_addr got=%h want=100", cap_addr); end
        if (cap_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b want=1111", cap_be); end
        if (cap_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h want=deadbeef", cap_wdata); end
        run_op("sb", ST, 3'd0, 32'h203, 32'h000000A5, 32'h0);
        total += 3;
        if (cap_addr !== 32'h200) begin bad++; $display("FAIL sb_addr got=%h want=200", cap_addr); end
        if (cap_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b want=1000", cap_be); end
        if (cap_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got=%h want=a5a5a5a5", cap_wdata); end
        run_op("sh", ST, 3'd1, 32'h302, 32'h0000BEEF, 32'h0);
    endtask

    task automatic test_load();
        run_op("lb", LD, 3'd0, 32'h102, 32'h0, 32'h12805634);
        total++;
        if (wb_data_out !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h want=ffffff80", wb_data_out); end
        run_op("lbu", LD, 3'd4, 32'h102, 32'h0, 32'h12805634);
        total++;
        if (wb_data_out !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h want=00000080", wb_data_out); end
        run_op("lhu", LD, 3'd5, 32'h102, 32'h0, 32'h12805634);
        total++;
        if (wb_data_out !== 32'h00001280) begin bad++; $display("FAIL lhu_data got=%h want=00001280", wb_data_out); end
        run_op("lh", LD, 3'd1, 32'h100, 32'h0, 32'h0000F00D);
        run_op("lw", LD, 3'd2, 32'h104, 32'h0, 32'h89ABCDEF);
    endtask

    task automatic test_fault();
        run_op("lw_mis", LD, 3'd2, 32'h106, 32'h0, 32'h0);
        total++;
        if ({err_out, err_cause_out} !== 3'b101) begin bad++; $display("FAIL lw_mis_cause got=%b want=101", {err_out, err_cause_out}); end
        run_op("ld_f3", LD, 3'd3, 32'h100, 32'h0, 32'h0);
        total++;
        if (err_cause_out !== 2'd2) begin bad++; $display("FAIL ld_illegal_cause got=%0d want=2", err_cause_out); end
        run_op("st_prio", ST, 3'd5, 32'h101, 32'h0, 32'h0);
        run_op("sh_mis", ST, 3'd1, 32'h101, 32'h0, 32'h0);
        // Non-memory opcode must be ignored.
        tick();
        req_valid_in = 1'b1; opcode_in = 7'b0110011;
        tick();
        tick();
        req_valid_in = 1'b0;
        total += 2;
        if (req_ready_out !== 1'b1 || mem_req_valid_out !== 1'b0) begin
            bad++; $display("FAIL other_op ready/valid got=%b%b want=10", req_ready_out, mem_req_valid_out);
        end
        if (done_out !== 1'b0) begin bad++; $display("FAIL other_op done got=%b want=0", done_out); end
    endtask

    task automatic test_timeout();
        int  w;
        bit  seen;
        mem_auto = 1'b0; rsp_pend = 1'b0; mem_req_ready_in = 1'b0; mem_rsp_valid_in = 1'b0;
        tick();
        req_valid_in = 1'b1; opcode_in = LD; funct3_in = 3'd2; addr_in = 32'h40;
        tick();
        req_valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (mem_req_valid_out !== 1'b1 || mem_addr_out !== 32'h40 || mem_be_out !== 4'hF || mem_we_out !== 1'b0) begin
                bad++; $display("FAIL stall_hold c%0d valid=%b addr=%h be=%b we=%b want 1/40/1111/0",
                                i, mem_req_valid_out, mem_addr_out, mem_be_out, mem_we_out);
            end
            tick();
        end
        mem_req_ready_in = 1'b1;
        tick();
        mem_req_ready_in = 1'b0;
        w = cyc;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done_out === 1'b1) seen = 1'b1;
            else tick();
        end
        total += 3;
        if (!seen || cyc - w !== 16) begin bad++; $display("FAIL timeout_latency got=%0d want=16", cyc - w); end
        if ({err_out, err_cause_out} !== 3'b111) begin bad++; $display("FAIL timeout_cause got=%b want=111", {err_out, err_cause_out}); end
        if (wb_valid_out !== 1'b0) begin bad++; $display("FAIL timeout_wbv got=%b want=0", wb_valid_out); end
        // Response on the final allowed cycle wins over the timeout.
        tick();
        req_valid_in = 1'b1; opcode_in = LD; funct3_in = 3'd2; addr_in = 32'h44;
        mem_req_ready_in = 1'b1;
        tick();
        req_valid_in = 1'b0;
        tick();
        mem_req_ready_in = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        total++;
        if (done_out !== 1'b0) begin bad++; $display("FAIL limit_early_done got=%b want=0", done_out); end
        mem_rsp_valid_in = 1'b1; mem_rdata_in = 32'h11223344;
        tick();
        mem_rsp_valid_in = 1'b0;
        total += 2;
        if ({done_out, err_out, wb_valid_out} !== 3'b101) begin
            bad++; $display("FAIL limit_rsp done/err/wbv got=%b want=101", {done_out, err_out, wb_valid_out});
        end
        if (wb_data_out !== 32'h11223344) begin bad++; $display("FAIL limit_rsp_data got=%h want=11223344", wb_data_out); end
        last_wb = 32'h11223344;
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 2; p++) begin
            mem_auto = 1'b0; rsp_pend = 1'b0; mem_req_ready_in = 1'b0; mem_rsp_valid_in = 1'b0;
            tick();
            req_valid_in = 1'b1; opcode_in = LD; funct3_in = 3'd2; addr_in = 32'h80;
            tick();
            req_valid_in = 1'b0;
            if (p == 1) begin
                mem_req_ready_in = 1'b1;
                tick();
                mem_req_ready_in = 1'b0;
            end
            #1 rst_in = 1'b1;
            #1;
            total += 2;
            if (mem_req_valid_out !== 1'b0 || done_out !== 1'b0) begin
                bad++; $display("FAIL mid_reset%0d valid/done got=%b%b want=00", p, mem_req_valid_out, done_out);
            end
            if (req_ready_out !== 1'b1) begin bad++; $display("FAIL mid_reset%0d ready got=%b want=1", p, req_ready_out); end
            #1 rst_in = 1'b0;
            last_wb = 32'h0;
            tick();
            mem_rsp_valid_in = 1'b1; mem_rdata_in = 32'h5555AAAA;
            tick();
            mem_rsp_valid_in = 1'b0;
            tick();
            total++;
            if ({done_out, wb_valid_out, req_ready_out} !== 3'b001 || wb_data_out !== 32'h0) begin
                bad++; $display("FAIL stale_rsp%0d done/wbv/ready=%b data=%h want 001/0",
                                p, {done_out, wb_valid_out, req_ready_out}, wb_data_out);
            end
        end
        mem_auto = 1'b1; rsp_pend = 1'b0;
        run_op("after_reset", LD, 3'd2, 32'h84, 32'h0, 32'hCAFEF00D);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 1) == 1) ? ST : LD;
            run_op("rand", op, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_fault();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
